mimasuo_supervisor: RTL

Sequencing controller for the push-button combination lock. Consumes the single-cycle digit pulses produced by the button level-to-pulse stages and collects a fixed-length code. It drives a timed unlock window, counts failed attempts, and enforces a lockout period with an alarm after repeated failures. It sits between the button pulse stages and the lock actuator, and replaces a free-running code FSM with a supervised, timed one.

---
 rtl/mimasuo_pkg.sv | 10 +
 rtl/mimasuo_supervisor_if.sv | 15 +
 rtl/mimasuo_timer.sv | 17 +
 rtl/mimasuo_supervisor.sv | 83 ++++++++
 4 files changed

// File: rtl/mimasuo_pkg.sv
// mimasuo_pkg: shared state encoding and timer sizing for the combination-lock supervisor.
package mimasuo_pkg;
  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;
  function automatic int timer_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/mimasuo_supervisor_if.sv
// mimasuo_supervisor_if: digit pulses in, lock status out.
interface mimasuo_supervisor_if #(
  parameter int CODE_LEN = 4,
  parameter int MAX_FAIL = 3
);
  logic zero_pulse;
  logic one_pulse;
  logic unlock;
  logic lockout;
  logic alarm;
  logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt;
  logic [$clog2(CODE_LEN+1)-1:0] digit_cnt;
  modport master(output zero_pulse, one_pulse, input unlock, lockout, alarm, fail_cnt, digit_cnt);
  modport slave(input zero_pulse, one_pulse, output unlock, lockout, alarm, fail_cnt, digit_cnt);
endinterface

// File: rtl/mimasuo_timer.sv
// mimasuo_timer: loadable down-counter; expire pulses in the last cycle of a loaded duration.
module mimasuo_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         expire
);
  logic [W-1:0] cnt;
  assign expire = cnt == W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/mimasuo_supervisor.sv
// mimasuo_supervisor: supervised combination-lock sequencer with unlock window, fail count and lockout.
// Define MIMASUO_TIMEOUT_EN to abandon a partial code after TIMEOUT_CYC idle cycles in ENTRY.
module mimasuo_supervisor
  import mimasuo_pkg::*;
#(
  parameter int                  CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0] CODE        = 4'b1010,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  UNLOCK_CYC  = 50_000_000,
  parameter int                  LOCKOUT_CYC = 500_000_000,
  parameter int                  TIMEOUT_CYC = 250_000_000
) (
  input logic                 clk,
  input logic                 rst,
  mimasuo_supervisor_if.slave bus
);
  localparam int DW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = timer_w(UNLOCK_CYC, LOCKOUT_CYC, TIMEOUT_CYC);
`ifdef MIMASUO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  state_t state, eff, nxt;
  logic [CODE_LEN-1:0] sr, sr_n, sr_q;
  logic [DW-1:0] cnt_n, dc_n;
  logic [FW-1:0] fb, fail_n, fc_n;
  logic [TW-1:0] load_val;
  logic dv, load, done, ok, expire, alarm_n;
  // An expiring duration is resolved first, so a same-cycle digit is seen from IDLE.
  always_comb begin
    dv = bus.zero_pulse ^ bus.one_pulse;
    eff = expire && (state == OPEN || state == LOCKOUT || (TO_EN && state == ENTRY)) ? IDLE : state;
    fb = state == LOCKOUT && expire ? '0 : bus.fail_cnt;
    sr_n = CODE_LEN'({eff == IDLE ? {CODE_LEN{1'b0}} : sr, bus.one_pulse});
    cnt_n = eff == IDLE ? DW'(1) : bus.digit_cnt + 1'b1;
    load = dv && (eff == IDLE || eff == ENTRY);
    done = load && cnt_n == DW'(CODE_LEN);
    ok = sr_n == CODE;
    fail_n = fb == FW'(MAX_FAIL) ? fb : fb + 1'b1;
    alarm_n = done && !ok && fail_n == FW'(MAX_FAIL);
    load_val = !done ? TW'(TIMEOUT_CYC) : ok ? TW'(UNLOCK_CYC) : TW'(LOCKOUT_CYC);
    nxt = eff == OPEN && bus.one_pulse && !bus.zero_pulse ? IDLE : eff;
    dc_n = eff == ENTRY ? bus.digit_cnt : '0;
    fc_n = fb;
    sr_q = load ? sr_n : sr;
    if (load && !done) begin
      nxt = ENTRY;
      dc_n = cnt_n;
    end
    if (done) begin
      nxt = ok ? OPEN : alarm_n ? LOCKOUT : IDLE;
      dc_n = '0;
      fc_n = ok ? '0 : fail_n;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      bus.digit_cnt <= '0;
      bus.fail_cnt <= '0;
      bus.unlock <= 1'b0;
      bus.lockout <= 1'b0;
      bus.alarm <= 1'b0;
    end else begin
      state <= nxt;
      sr <= sr_q;
      bus.digit_cnt <= dc_n;
      bus.fail_cnt <= fc_n;
      bus.unlock <= nxt == OPEN;
      bus.lockout <= nxt == LOCKOUT;
      bus.alarm <= alarm_n;
    end
  mimasuo_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .val(load_val),
    .expire(expire)
  );
endmodule
